store_buffer: RTL and testbench

//  Store queue between the EX/MEM pipeline register and DataMemory. Retires stores
//  (word, half, byte) into a DEPTH-entry FIFO, drains one per cycle into DataMemory

---
 rtl/store_buffer_if.sv | 31 +++
 rtl/store_buffer.sv | 119 +++++++++++
 tb/tb_store_buffer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Bundle of the store-buffer ports: MEM-stage store/load requests plus the
// DataMemory port. The buffer itself uses the slave modport.
interface store_buffer_if #(
  parameter int AW = 32
);
  logic          StReq;
  logic [AW-1:0] StAddr;
  logic [31:0]   StData;
  logic [1:0]    StByte;
  logic          StReady;
  logic          LdReq;
  logic [AW-1:0] LdAddr;
  logic [31:0]   LdData;
  logic          LdStall;
  logic [31:0]   MemRdData;
  logic [AW-1:0] MemAddr;
  logic [31:0]   MemWData;
  logic          MemWrite;
  logic          MemRead;
  logic [1:0]    MByte;

  modport master (
    output StReq, StAddr, StData, StByte, LdReq, LdAddr, MemRdData,
    input  StReady, LdData, LdStall, MemAddr, MemWData, MemWrite, MemRead, MByte
  );

  modport slave (
    input  StReq, StAddr, StData, StByte, LdReq, LdAddr, MemRdData,
    output StReady, LdData, LdStall, MemAddr, MemWData, MemWrite, MemRead, MByte
  );
endinterface

// File: rtl/store_buffer.sv
// Store queue in front of DataMemory: FIFO of pending stores, one memory access
// per cycle, loads forwarded or stalled on address hits. Word forwarding is
// enabled by defining STBUF_FWD_EN; otherwise any hit stalls until drained.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input logic          Clk,
  input logic          Reset,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [1:0]    byte_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [DEPTH-1:0] match;
  logic             hit;
  logic             push;
  logic             drain;
  logic             load_port;

  // An entry is live when its distance from head is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [PW-1:0] off;
    assign off       = PW'(gi) - head_q;
    assign match[gi] = ({1'b0, off} < count_q) && (addr_q[gi] == sb.LdAddr);
  end

  assign hit = |match;

`ifdef STBUF_FWD_EN
  logic [PW-1:0] hit_idx;
  logic          hit_word;
  logic          fwd;

  // Walk from oldest to youngest so the last live hit is the youngest store.
  always_comb begin
    hit_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[head_q + PW'(k)]) hit_idx = head_q + PW'(k);
    end
  end

  assign hit_word = (byte_q[hit_idx] == 2'b00) || (byte_q[hit_idx] == 2'b11);
  assign fwd      = hit && hit_word;
`endif

  // A forwarded load leaves the port free for the drain.
  assign load_port = !Reset && sb.LdReq && !hit;
  assign drain     = !Reset && !load_port && (count_q != '0);
  assign push      = !Reset && sb.StReq && (count_q != FULL);

  always_comb begin
    head_d  = drain ? head_q + PW'(1) : head_q;
    tail_d  = push  ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(drain);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is deliberately left unreset; liveness comes from count.
  always_ff @(posedge Clk) begin
    if (push) begin
      addr_q[tail_q] <= sb.StAddr;
      data_q[tail_q] <= sb.StData;
      byte_q[tail_q] <= sb.StByte;
    end
  end

  always_comb begin
    sb.StReady  = 1'b0;
    sb.LdData   = '0;
    sb.LdStall  = 1'b0;
    sb.MemAddr  = '0;
    sb.MemWData = '0;
    sb.MemWrite = 1'b0;
    sb.MemRead  = 1'b0;
    sb.MByte    = 2'b00;
    if (!Reset) begin
      sb.StReady = (count_q != FULL);
      if (sb.LdReq) begin
`ifdef STBUF_FWD_EN
        sb.LdStall = hit && !hit_word;
        sb.LdData  = fwd ? data_q[hit_idx] : sb.MemRdData;
`else
        sb.LdStall = hit;
        sb.LdData  = sb.MemRdData;
`endif
      end
      if (load_port) begin
        sb.MemRead = 1'b1;
        sb.MemAddr = sb.LdAddr;
      end else if (drain) begin
        sb.MemWrite = 1'b1;
        sb.MemAddr  = addr_q[head_q];
        sb.MemWData = data_q[head_q];
        sb.MByte    = byte_q[head_q];
      end
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-based reference model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
`ifdef STBUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_buffer_if #(.AW(AW)) sb_if ();

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk   (clk),
    .Reset (rst),
    .sb    (sb_if.slave)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [1:0]    byt;
  } ent_t;

  typedef struct {
    logic          st_ready;
    logic          ld_stall;
    logic [31:0]   ld_data;
    logic          mem_write;
    logic          mem_read;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [1:0]    mbyte;
    bit            chk_ld;
    bit            chk_wd;
  } exp_t;

  ent_t sbq[$];
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, req);
    end
  endtask

  // One cycle of stimulus; the model predicts outputs from the pre-edge queue.
  task automatic drive(input bit r, input bit sreq, input logic [AW-1:0] sa,
                       input logic [31:0] sd, input logic [1:0] sbt,
                       input bit lreq, input logic [AW-1:0] la);
    exp_t e;
    ent_t m;
    bit   found;
    bit   full_before;
    logic [31:0] rd;
    @(posedge clk);
    #1;
    rd = $urandom;
    rst = r;
    sb_if.StReq = sreq;  sb_if.StAddr = sa;  sb_if.StData = sd;  sb_if.StByte = sbt;
    sb_if.LdReq = lreq;  sb_if.LdAddr = la;  sb_if.MemRdData = rd;
    e = '{default: '0};
    e.chk_ld = 1'b1;
    e.chk_wd = 1'b1;
    if (r) begin
      sbq.delete();
    end else begin
      e.st_ready = (sbq.size() != DEPTH);
      found = 1'b0;
      m = '{default: '0};
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].addr == la) begin
          found = 1'b1;
          m = sbq[i];
          break;
        end
      end
      if (lreq) begin
        if (!found) e.ld_data = rd;
        else if (FWD && (m.byt == 2'b00 || m.byt == 2'b11)) e.ld_data = m.data;
        else begin
          e.ld_stall = 1'b1;
          e.chk_ld   = 1'b0;
        end
      end
      full_before = (sbq.size() == DEPTH);
      if (lreq && !found) begin
        e.mem_read = 1'b1;
        e.mem_addr = la;
        e.chk_wd   = 1'b0;
      end else if (sbq.size() != 0) begin
        e.mem_write = 1'b1;
        e.mem_addr  = sbq[0].addr;
        e.mem_wdata = sbq[0].data;
        e.mbyte     = sbq[0].byt;
        void'(sbq.pop_front());
      end
      if (sreq && !full_before) sbq.push_back('{addr: sa, data: sd, byt: sbt});
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 2'b00, 0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cyc++;
        $display("cyc %0d: rst=%0b st=%0b ld=%0b -> rdy=%0b stall=%0b wr=%0b rd=%0b addr=%h wd=%h mb=%0d ld_data=%h",
                 cyc, rst, sb_if.StReq, sb_if.LdReq, sb_if.StReady, sb_if.LdStall,
                 sb_if.MemWrite, sb_if.MemRead, sb_if.MemAddr, sb_if.MemWData,
                 sb_if.MByte, sb_if.LdData);
        check("StReady", 32'(sb_if.StReady), 32'(e.st_ready));
        check("LdStall", 32'(sb_if.LdStall), 32'(e.ld_stall));
        check("MemWrite", 32'(sb_if.MemWrite), 32'(e.mem_write));
        check("MemRead", 32'(sb_if.MemRead), 32'(e.mem_read));
        check("MemAddr", sb_if.MemAddr, e.mem_addr);
        if (e.chk_ld) check("LdData", sb_if.LdData, e.ld_data);
        if (e.chk_wd) begin
          check("MemWData", sb_if.MemWData, e.mem_wdata);
          check("MByte", 32'(sb_if.MByte), 32'(e.mbyte));
        end
      end
    end
  end

  initial begin : stimulus
    sb_if.StReq = 0; sb_if.StAddr = '0; sb_if.StData = '0; sb_if.StByte = '0;
    sb_if.LdReq = 0; sb_if.LdAddr = '0; sb_if.MemRdData = '0;
    drive(1, 0, '0, '0, 2'b00, 0, '0);
    drive(1, 1, 32'd5, 32'h1234_5678, 2'b00, 1, 32'd5);
    // Single word store drains on the next cycle.
    drive(0, 1, 32'd5, 32'hDEAD_BEEF, 2'b00, 0, '0);
    idle(2);
    // Held load owns the port; the buffer fills and the fifth push is dropped.
    for (int i = 0; i < 5; i++) drive(0, 1, 32'(20 + i), 32'(32'hA000_0000 + i), 2'(i), 1, 32'd9);
    idle(5);
    // Two word stores to one address; the load sees the younger one.
    drive(0, 1, 32'd3, 32'h1111_1111, 2'b00, 0, '0);
    drive(0, 1, 32'd3, 32'h2222_2222, 2'b00, 0, '0);
    drive(0, 0, '0, '0, 2'b00, 1, 32'd3);
    drive(0, 0, '0, '0, 2'b00, 1, 32'd3);
    drive(0, 0, '0, '0, 2'b00, 1, 32'd3);
    idle(2);
    // Byte store hit stalls the load until it drains.
    drive(0, 1, 32'd7, 32'h0000_00AB, 2'b10, 0, '0);
    drive(0, 0, '0, '0, 2'b00, 1, 32'd7);
    drive(0, 0, '0, '0, 2'b00, 1, 32'd7);
    idle(1);
    // Full buffer with a concurrent drain, then push/drain pairs across the wrap.
    for (int i = 0; i < 4; i++) drive(0, 1, 32'(40 + i), 32'(32'hB000_0000 + i), 2'b00, 1, 32'd9);
    drive(0, 1, 32'd50, 32'hC0DE_0000, 2'b00, 0, '0);
    for (int i = 0; i < 10; i++) drive(0, 1, 32'(60 + i), 32'(32'hD000_0000 + i), 2'(i), 0, '0);
    idle(4);
    // Reset with pending stores discards them.
    for (int i = 0; i < 3; i++) drive(0, 1, 32'(70 + i), 32'(32'hE000_0000 + i), 2'b00, 1, 32'd9);
    drive(1, 0, '0, '0, 2'b00, 1, 32'd9);
    idle(3);
    // Randomized traffic over a small address space to provoke hits.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 99) < 60,
            32'($urandom_range(0, 7)),
            $urandom,
            2'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 45,
            32'($urandom_range(0, 7)));
    end
    idle(6);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
